// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receive end of the serial shift-register link. Watches a one-bit-per-clock
//   line, detects a start bit, shifts in DATA_WIDTH data bits MSB first, checks
//   the stop bit and hands each good word to parallel logic through a
//   one-entry valid/ready holding buffer.
//
//   Optional feature: define PARITY_CHECK_EN to add an even-parity bit between
//   the data bits and the stop bit. Without it Parity_Error_Out is tied 0.
//
// Ports
//   Clk_In           clock, everything on the rising edge
//   Reset_In         synchronous active-high reset
//   Serial_Data_In   serial line, one bit sampled per clock
//   Data_Out         received word, stable while Data_Valid_Out=1
//   Data_Valid_Out   holding buffer full
//   Data_Ready_In    consumer accepts the word when valid & ready
//   Busy_Out         receiver is inside a frame (not idle)
//   Frame_Error_Out  one-cycle pulse, bad stop bit, frame discarded
//   Overrun_Out      one-cycle pulse, good frame dropped because buffer full
//   Parity_Error_Out one-cycle pulse, parity mismatch, frame discarded
module serial_frame_receiver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Serial_Data_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid_Out,
  input  logic                  Data_Ready_In,
  output logic                  Busy_Out,
  output logic                  Frame_Error_Out,
  output logic                  Overrun_Out,
  output logic                  Parity_Error_Out
);

  localparam int unsigned CntWidth = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  // Frame passed its checks at the stop edge; the buffer load happens one edge
  // later. shift_q is untouched in StIdle, so it still holds the word then,
  // even if a back-to-back start bit is being sampled at that same edge.
  logic                  good_q, good_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_bit;
`ifdef PARITY_CHECK_EN
  logic                  par_bad_q, par_bad_d;
  logic                  parity_err_q, parity_err_d;
`endif

  assign last_bit = (cnt_q == CntWidth'(DATA_WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    good_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef PARITY_CHECK_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (Serial_Data_In == ~IDLE_LEVEL) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        shift_d = {shift_q[DATA_WIDTH-2:0], Serial_Data_In};
        cnt_d   = cnt_q + CntWidth'(1);
        if (last_bit) begin
`ifdef PARITY_CHECK_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
      StParity: begin
`ifdef PARITY_CHECK_EN
        // Even parity: XOR of data bits and parity bit must be 0.
        par_bad_d = (^shift_q) ^ Serial_Data_In;
`endif
        state_d = StStop;
      end
      StStop: begin
        state_d     = StIdle;
        frame_err_d = (Serial_Data_In != IDLE_LEVEL);
`ifdef PARITY_CHECK_EN
        parity_err_d = par_bad_q;
        good_d       = (Serial_Data_In == IDLE_LEVEL) && !par_bad_q;
`else
        good_d       = (Serial_Data_In == IDLE_LEVEL);
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      cnt_q       <= '0;
      good_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
      if (good_q) begin
        // Load is allowed into an empty buffer or one being drained this edge.
        if (!valid_q || Data_Ready_In) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && Data_Ready_In) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign Data_Out        = data_q;
  assign Data_Valid_Out  = valid_q;
  assign Busy_Out        = (state_q != StIdle);
  assign Frame_Error_Out = frame_err_q;
  assign Overrun_Out     = overrun_q;
`ifdef PARITY_CHECK_EN
  assign Parity_Error_Out = parity_err_q;
`else
  assign Parity_Error_Out = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver. The stimulus is built as whole frames in
// per-cycle arrays; frame positions give the cycles at which loads, errors and
// busy are due, and a small buffer model turns those into expected outputs.
module tb_serial_frame_receiver;

  localparam int DW   = 8;
  localparam int MAXC = 4000;
`ifdef PARITY_CHECK_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          line = 1'b1;
  logic          rdy = 1'b0;
  logic [DW-1:0] dout;
  logic          dvalid, busy, ferr, ovr, perr;

  serial_frame_receiver #(
    .DATA_WIDTH(DW),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .Clk_In          (clk),
    .Reset_In        (rst),
    .Serial_Data_In  (line),
    .Data_Out        (dout),
    .Data_Valid_Out  (dvalid),
    .Data_Ready_In   (rdy),
    .Busy_Out        (busy),
    .Frame_Error_Out (ferr),
    .Overrun_Out     (ovr),
    .Parity_Error_Out(perr)
  );

  always #5 clk = ~clk;

  // Stimulus and events, indexed by rising-edge number.
  logic          line_a[MAXC], rst_a[MAXC], rdy_a[MAXC];
  logic          load_a[MAXC], ferr_a[MAXC], perr_a[MAXC], busy_a[MAXC];
  logic [DW-1:0] lword_a[MAXC];
  // Expected and recorded outputs after each edge.
  logic [12:0]   exp_a[MAXC];
  logic          d_v[MAXC], d_b[MAXC], d_fe[MAXC], d_ov[MAXC], d_pe[MAXC];
  logic [DW-1:0] d_dat[MAXC];

  int n = 0;
  int rdy_mode = 1;  // 0: low, 1: high, 2: random
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic push(input logic b, input logic r);
    if (n >= MAXC) begin
      $display("FAIL stimulus_overflow: got %0d expected < %0d", n, MAXC);
      $fatal(1, "stimulus table full");
    end
    line_a[n] = b;
    rst_a[n]  = r;
    rdy_a[n]  = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) push(1'b1, 1'b0);
  endtask

  // Start bit at edge s, data s+1..s+DW, [parity], stop at e; pulses after e,
  // load at e+1.
  task automatic send_frame(input logic [DW-1:0] w, input bit stop_ok, input bit par_ok);
    int s, e;
    s = n;
    push(1'b0, 1'b0);
    for (int i = DW - 1; i >= 0; i--) push(w[i], 1'b0);
    if (P == 1) push((^w) ^ !par_ok, 1'b0);
    e = n;
    push(stop_ok ? 1'b1 : 1'b0, 1'b0);
    for (int c = s; c < e; c++) busy_a[c] = 1'b1;
    ferr_a[e] = !stop_ok;
    perr_a[e] = (P == 1) && !par_ok;
    if (stop_ok && par_ok) begin
      load_a[e+1]  = 1'b1;
      lword_a[e+1] = w;
    end
  endtask

  // Start bit, k data bits, then reset at the next edge.
  task automatic reset_mid(input logic [DW-1:0] w, input int k);
    int s;
    s = n;
    push(1'b0, 1'b0);
    for (int i = 0; i < k; i++) push(w[DW-1-i], 1'b0);
    for (int c = s; c <= s + k; c++) busy_a[c] = 1'b1;
    push(1'b1, 1'b1);
  endtask

  int t1, t2, t3, t4, t5, t6, t7, t8, t9, cnt;
  logic          mv, mov, tr;
  logic [DW-1:0] md;

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      line_a[c] = 1'b1; rst_a[c] = 1'b0; rdy_a[c] = 1'b0;
      load_a[c] = 1'b0; ferr_a[c] = 1'b0; perr_a[c] = 1'b0; busy_a[c] = 1'b0;
      lword_a[c] = '0; exp_a[c] = '0;
    end

    // ---------------- stimulus ----------------
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1);
    idle(20);
    t1 = n; send_frame(8'hA5, 1, 1); idle(3);
    rdy_mode = 0;
    t2 = n; send_frame(8'hA5, 1, 1); send_frame(8'h3C, 1, 1); idle(3);
    rdy_mode = 1;
    t3 = n; idle(3);
    t4 = n; send_frame(8'h3C, 0, 1);
    rdy_mode = 0;
    t5 = n; send_frame(8'h81, 1, 1); idle(3);
    t6 = n; reset_mid(8'hC3, 4);
    rdy_mode = 1; idle(2);
    t7 = n; send_frame(8'hFF, 1, 1); idle(3);
    t8 = n; t9 = n;
    if (P == 1) begin
      t8 = n; send_frame(8'h0F, 1, 1); idle(2);
      t9 = n; send_frame(8'h0F, 1, 0); idle(3);
    end
    rdy_mode = 2;
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset_mid(DW'($urandom), int'($urandom_range(0, DW - 1)));
        idle(1);
      end else begin
        send_frame(DW'($urandom), $urandom_range(0, 7) != 0,
                   (P == 0) || ($urandom_range(0, 7) != 0));
        idle(int'($urandom_range(0, 3)));
      end
    end
    idle(5);

    // ---------------- model: buffer rules applied per edge ----------------
    mv = 1'b0; md = '0; mov = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (rst_a[c]) begin
        mv = 1'b0; md = '0; mov = 1'b0;
        exp_a[c] = {1'b0, 4'b0000, DW'(0)};
      end else begin
        tr  = mv & rdy_a[c];
        mov = 1'b0;
        if (load_a[c]) begin
          if (!mv || tr) begin
            md = lword_a[c]; mv = 1'b1;
          end else begin
            mov = 1'b1;
          end
        end else if (tr) begin
          mv = 1'b0;
        end
        exp_a[c] = {mv, busy_a[c], ferr_a[c], mov, perr_a[c], md};
      end
    end

    // ---------------- run and compare ----------------
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c > 0) begin
        d_v[c-1] = dvalid; d_b[c-1] = busy; d_fe[c-1] = ferr;
        d_ov[c-1] = ovr; d_pe[c-1] = perr; d_dat[c-1] = dout;
        chk($sformatf("cycle%0d{v,busy,fe,ov,pe,data}", c - 1),
            32'({dvalid, busy, ferr, ovr, perr, dout}), 32'(exp_a[c-1]));
      end
      if (c < n) begin
        line = line_a[c]; rst = rst_a[c]; rdy = rdy_a[c];
      end
    end

    // ---------------- hand-computed expectations ----------------
    cnt = 0;
    for (int c = 3; c < t1; c++) cnt += int'(d_v[c]) + int'(d_b[c]) + int'(d_fe[c]) +
                                       int'(d_ov[c]) + int'(d_pe[c]);
    chk("idle_quiet", 32'(cnt), 32'd0);
    chk("a5_data", 32'(d_dat[t1+DW+2+P]), 32'hA5);
    chk("a5_valid_rise", 32'(d_v[t1+DW+2+P]), 32'd1);
    chk("a5_valid_prev", 32'(d_v[t1+DW+1+P]), 32'd0);
    chk("a5_valid_fall", 32'(d_v[t1+DW+3+P]), 32'd0);
    cnt = 0;
    for (int c = t2; c < t3; c++) cnt += int'(d_ov[c]);
    chk("overrun_once", 32'(cnt), 32'd1);
    chk("overrun_kept", 32'(d_dat[t3-1]), 32'hA5);
    chk("overrun_kept_valid", 32'(d_v[t3-1]), 32'd1);
    chk("drain_fall", 32'(d_v[t3]), 32'd0);
    chk("ferr_pulse", 32'(d_fe[t4+DW+1+P]), 32'd1);
    chk("ferr_no_valid", 32'(d_v[t4+DW+2+P]), 32'd0);
    chk("after_ferr_data", 32'(d_dat[t5+DW+2+P]), 32'h81);
    chk("after_ferr_valid", 32'(d_v[t5+DW+2+P]), 32'd1);
    chk("pre_reset_valid", 32'(d_v[t6+4]), 32'd1);
    chk("reset_mid_out",
        32'({d_v[t6+5], d_b[t6+5], d_fe[t6+5], d_ov[t6+5], d_pe[t6+5], d_dat[t6+5]}),
        32'd0);
    chk("ff_data", 32'(d_dat[t7+DW+2+P]), 32'hFF);
    chk("ff_valid", 32'(d_v[t7+DW+2+P]), 32'd1);
    if (P == 1) begin
      chk("par_ok_data", 32'(d_dat[t8+DW+3]), 32'h0F);
      chk("par_ok_valid", 32'(d_v[t8+DW+3]), 32'd1);
      chk("par_bad_pulse", 32'(d_pe[t9+DW+2]), 32'd1);
      chk("par_bad_no_valid", 32'(d_v[t9+DW+3]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
